// File: rtl/fsm_flow_ctrl.sv
// Flow-control sequencer for the N-FIFO bank: RESET -> INIT -> IDLE <-> ACTIVE plus sticky ERROR.
// Latches thresholds in INIT and drives per-FIFO pause requests with hysteresis.
module fsm_flow_ctrl #(
  parameter int N_FIFO    = 8,
  parameter int CNT_W     = 4,
  parameter int IDLE_HOLD = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [CNT_W-1:0]        umbral_low,
  input  logic [CNT_W-1:0]        umbral_high,
  input  logic [N_FIFO*CNT_W-1:0] fifo_count,
  input  logic [N_FIFO-1:0]       fifo_empty,
  input  logic [N_FIFO-1:0]       fifo_err,
  output logic [2:0]              state,
  output logic [2:0]              nxt_state,
  output logic [CNT_W-1:0]        umbral_low_out,
  output logic [CNT_W-1:0]        umbral_high_out,
  output logic [N_FIFO-1:0]       pause,
  output logic [N_FIFO-1:0]       error_vec,
  output logic                    idle_out,
  output logic                    active_out,
  output logic                    error_out
);

  localparam int HOLD_W = (IDLE_HOLD > 1) ? $clog2(IDLE_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(IDLE_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]    low_q, low_d;
  logic [CNT_W-1:0]    high_q, high_d;
  logic [N_FIFO-1:0]   pause_q, pause_d;
  logic [N_FIFO-1:0]   error_vec_q, error_vec_d;
  logic                idle_q, idle_d;
  logic                active_q, active_d;
  logic                error_q, error_d;

  logic [N_FIFO-1:0]   hyst_pause;
  logic                any_err;
  logic                all_empty;
  logic                thr_ok;

  assign any_err   = |fifo_err;
  assign all_empty = &fifo_empty;
  assign thr_ok    = (umbral_low < umbral_high);

  // State register and all datapath flops; reset dominates everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_RESET;
      hold_q      <= '0;
      low_q       <= '0;
      high_q      <= '0;
      pause_q     <= '0;
      error_vec_q <= '0;
      idle_q      <= 1'b0;
      active_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      low_q       <= low_d;
      high_q      <= high_d;
      pause_q     <= pause_d;
      error_vec_q <= error_vec_d;
      idle_q      <= idle_d;
      active_q    <= active_d;
      error_q     <= error_d;
    end
  end

  // Next-state logic, including the ACTIVE all-empty hold counter.
  always_comb begin
    state_d = ST_RESET;
    hold_d  = '0;
    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT: begin
        if (!init) begin
          state_d = ST_INIT;
        end else if (thr_ok) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ERROR;
        end
      end
      ST_IDLE: begin
        if (any_err) begin
          state_d = ST_ERROR;
        end else if (all_empty) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (any_err) begin
          state_d = ST_ERROR;
        end else if (all_empty) begin
          // Counter holds the number of all-empty cycles already seen.
          if (hold_q == HOLD_LAST) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ACTIVE;
            hold_d  = hold_q + HOLD_ONE;
          end
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ERROR: begin
        if (init) begin
          state_d = ST_INIT;
        end else begin
          state_d = ST_ERROR;
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  // Per-FIFO hysteresis: high threshold wins, then low threshold, else hold.
  always_comb begin
    hyst_pause = pause_q;
    for (int i = 0; i < N_FIFO; i++) begin
      if (fifo_count[i*CNT_W +: CNT_W] >= high_q) begin
        hyst_pause[i] = 1'b1;
      end else if (fifo_count[i*CNT_W +: CNT_W] <= low_q) begin
        hyst_pause[i] = 1'b0;
      end else begin
        hyst_pause[i] = pause_q[i];
      end
    end
  end

  // Output logic: thresholds, pause, error record and state decode flags.
  always_comb begin
    low_d       = low_q;
    high_d      = high_q;
    pause_d     = '0;
    error_vec_d = error_vec_q;

    // An invalid pair with init=1 must leave the previous thresholds untouched.
    if ((state_q == ST_INIT) && (!init || thr_ok)) begin
      low_d  = umbral_low;
      high_d = umbral_high;
    end else begin
      low_d  = low_q;
      high_d = high_q;
    end

    case (state_q)
      ST_IDLE, ST_ACTIVE: pause_d = hyst_pause;
      ST_ERROR:           pause_d = '1;
      default:            pause_d = '0;
    endcase

    if ((state_q == ST_ERROR) && init) begin
      error_vec_d = '0;
    end else if (state_q != ST_RESET) begin
      error_vec_d = error_vec_q | fifo_err;
    end else begin
      error_vec_d = error_vec_q;
    end

    idle_d   = (state_d == ST_IDLE);
    active_d = (state_d == ST_ACTIVE);
    error_d  = (state_d == ST_ERROR);
  end

  assign state           = state_q;
  assign nxt_state       = state_d;
  assign umbral_low_out  = low_q;
  assign umbral_high_out = high_q;
  assign pause           = pause_q;
  assign error_vec       = error_vec_q;
  assign idle_out        = idle_q;
  assign active_out      = active_q;
  assign error_out       = error_q;

endmodule

// File: tb/tb_fsm_flow_ctrl.sv
// Scoreboard bench for fsm_flow_ctrl: directed scenarios then random traffic,
// expected values from a rule-level reference model queued per clock edge.
module tb_fsm_flow_ctrl;

  localparam int N = 8;
  localparam int W = 4;
  localparam int H = 4;
  localparam int S_RESET = 0, S_INIT = 1, S_IDLE = 2, S_ACTIVE = 3, S_ERROR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset, init;
  logic [W-1:0]   umbral_low, umbral_high;
  logic [N*W-1:0] fifo_count;
  logic [N-1:0]   fifo_empty, fifo_err;
  logic [2:0]     state, nxt_state;
  logic [W-1:0]   umbral_low_out, umbral_high_out;
  logic [N-1:0]   pause, error_vec;
  logic           idle_out, active_out, error_out;

  fsm_flow_ctrl #(.N_FIFO(N), .CNT_W(W), .IDLE_HOLD(H)) dut (
    .clk(clk), .reset(reset), .init(init),
    .umbral_low(umbral_low), .umbral_high(umbral_high),
    .fifo_count(fifo_count), .fifo_empty(fifo_empty), .fifo_err(fifo_err),
    .state(state), .nxt_state(nxt_state),
    .umbral_low_out(umbral_low_out), .umbral_high_out(umbral_high_out),
    .pause(pause), .error_vec(error_vec),
    .idle_out(idle_out), .active_out(active_out), .error_out(error_out)
  );

  typedef struct {
    logic [2:0]   st;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic [N-1:0] pz;
    logic [N-1:0] ev;
    logic [2:0]   flags;
  } exp_t;

  exp_t sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int           m_state = S_RESET;
  logic [W-1:0] m_lo = '0, m_hi = '0;
  logic [N-1:0] m_pz = '0, m_ev = '0;
  int           m_run = 0;
  int           cnt[N];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock edge worth of behaviour, from the current inputs.
  task automatic model_step();
    int ns;
    logic [W-1:0] nlo, nhi;
    logic [N-1:0] npz, nev;
    exp_t e;
    ns = m_state; nlo = m_lo; nhi = m_hi; npz = m_pz; nev = m_ev;
    if (!reset) begin
      ns = S_RESET; nlo = '0; nhi = '0; npz = '0; nev = '0; m_run = 0;
    end else begin
      if (m_state == S_IDLE || m_state == S_ACTIVE) begin
        for (int i = 0; i < N; i++) begin
          if (cnt[i] >= int'(m_hi)) npz[i] = 1'b1;
          else if (cnt[i] <= int'(m_lo)) npz[i] = 1'b0;
        end
      end else if (m_state == S_ERROR) npz = '1;
      else npz = '0;

      if (m_state == S_ERROR && init) nev = '0;
      else if (m_state != S_RESET) nev = m_ev | fifo_err;

      case (m_state)
        S_RESET: ns = S_INIT;
        S_INIT: begin
          if (!init) begin
            nlo = umbral_low; nhi = umbral_high;
          end else if (umbral_low < umbral_high) begin
            nlo = umbral_low; nhi = umbral_high; ns = S_IDLE;
          end else ns = S_ERROR;
        end
        S_IDLE: begin
          if (fifo_err != 0) ns = S_ERROR;
          else if (fifo_empty != {N{1'b1}}) ns = S_ACTIVE;
        end
        S_ACTIVE: begin
          if (fifo_err != 0) ns = S_ERROR;
          else if (fifo_empty == {N{1'b1}}) begin
            m_run++;
            if (m_run >= H) ns = S_IDLE;
          end else m_run = 0;
        end
        S_ERROR: if (init) ns = S_INIT;
        default: ns = S_RESET;
      endcase
      if (ns != S_ACTIVE) m_run = 0;
    end
    m_state = ns; m_lo = nlo; m_hi = nhi; m_pz = npz; m_ev = nev;
    e.st = 3'(ns); e.lo = nlo; e.hi = nhi; e.pz = npz; e.ev = nev;
    e.flags = {ns == S_ERROR, ns == S_ACTIVE, ns == S_IDLE};
    sb_q.push_back(e);
  endtask

  task automatic tick();
    for (int i = 0; i < N; i++) fifo_count[i*W +: W] = W'(cnt[i]);
    model_step();
    @(posedge clk);
    #2;
  endtask

  // Monitor: after every edge, pop the expected record and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("state", 32'(state), 32'(e.st));
        check("thr_low", 32'(umbral_low_out), 32'(e.lo));
        check("thr_high", 32'(umbral_high_out), 32'(e.hi));
        check("pause", 32'(pause), 32'(e.pz));
        check("error_vec", 32'(error_vec), 32'(e.ev));
        check("flags", 32'({error_out, active_out, idle_out}), 32'(e.flags));
      end
    end
  end

  initial begin
    reset = 1'b0; init = 1'b0; umbral_low = 4'd2; umbral_high = 4'd6;
    fifo_empty = 8'hFF; fifo_err = 8'h00; fifo_count = '0;
    for (int i = 0; i < N; i++) cnt[i] = 0;

    // Reset, INIT with 2/6, then IDLE
    repeat (3) tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_pause", 32'(pause), 32'd0);
    reset = 1'b1;
    repeat (2) tick();
    check("init_state", 32'(state), 32'd1);
    init = 1'b1;
    tick();
    init = 1'b0;
    check("idle_state", 32'(state), 32'd2);
    check("idle_thr", 32'({umbral_low_out, umbral_high_out}), 32'h26);
    check("idle_out", 32'(idle_out), 32'd1);

    // Hysteresis on FIFO 0
    fifo_empty = 8'hFE;
    for (int v = 0; v <= 7; v++) begin
      cnt[0] = v;
      tick();
      if (v == 0) check("to_active", 32'(state), 32'd3);
      if (v == 5) check("p0_below_high", 32'(pause[0]), 32'd0);
      if (v == 6) check("p0_at_high", 32'(pause[0]), 32'd1);
    end
    for (int v = 6; v >= 0; v--) begin
      cnt[0] = v;
      tick();
      if (v == 3) check("p0_hold", 32'(pause[0]), 32'd1);
      if (v == 2) check("p0_at_low", 32'(pause[0]), 32'd0);
    end

    // Idle hold: 3 empty cycles is not enough, 4 is
    fifo_empty = 8'hFF;
    repeat (3) tick();
    check("hold3_active", 32'(state), 32'd3);
    fifo_empty = 8'hFE;
    tick();
    fifo_empty = 8'hFF;
    repeat (3) tick();
    check("hold3b_active", 32'(state), 32'd3);
    tick();
    check("hold4_idle", 32'(state), 32'd2);

    // Error entry and recovery
    fifo_empty = 8'hFE;
    tick();
    fifo_err = 8'h20;
    tick();
    fifo_err = 8'h00;
    check("err_state", 32'(state), 32'd4);
    check("err_vec", 32'(error_vec), 32'h20);
    tick();
    check("err_pause", 32'(pause), 32'hFF);
    init = 1'b1;
    tick();
    init = 1'b0;
    check("clr_state", 32'(state), 32'd1);
    check("clr_vec", 32'(error_vec), 32'd0);
    tick();
    check("clr_pause", 32'(pause), 32'd0);

    // Invalid thresholds: low == high
    umbral_low = 4'd5; umbral_high = 4'd5; init = 1'b1;
    tick();
    check("bad_thr_state", 32'(state), 32'd4);
    check("bad_thr_keep", 32'({umbral_low_out, umbral_high_out}), 32'h26);
    tick();
    init = 1'b0; umbral_low = 4'd2; umbral_high = 4'd6;
    tick();
    init = 1'b1;
    tick();
    init = 1'b0;

    // Reset while ACTIVE with pause 8'h81
    cnt[0] = 7; cnt[7] = 7; fifo_empty = 8'h7E;
    repeat (2) tick();
    check("p81_state", 32'(state), 32'd3);
    check("p81_pause", 32'(pause), 32'h81);
    reset = 1'b0;
    tick();
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_pause", 32'(pause), 32'd0);
    check("mid_rst_thr", 32'({umbral_low_out, umbral_high_out}), 32'd0);
    check("mid_rst_active", 32'(active_out), 32'd0);
    reset = 1'b1;

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      reset       = ($urandom_range(0, 99) != 0);
      init        = ($urandom_range(0, 3) == 0);
      umbral_low  = W'($urandom_range(0, 15));
      umbral_high = W'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) cnt[i] = $urandom_range(0, 15);
      fifo_empty  = ($urandom_range(0, 1) == 0) ? 8'hFF : N'($urandom);
      fifo_err    = ($urandom_range(0, 29) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
      tick();
    end

    for (int k = 0; k < 4 && sb_q.size() > 0; k++) begin
      @(posedge clk);
      #2;
    end
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
